csr_bus_arbiter: RTL and testbench
==================================

// Module: csr_bus_arbiter
// PURPOSE
//  Shares the single-port CSR register file between NUM_REQ masters (req 0 = csr_spi host bridge,
//  req 1 = NKMD debug port, further slots spare). Round-robin grant, per-master lock for
//  auto-increment SPI bursts, lock-hold watchdog, fixed read latency. Sits between the masters
//  and the csr register bank.
// PARAMETERS
//  NUM_REQ     2    number of requesting masters (>=2)
//  ADDR_W      12   CSR address width
//  DATA_W      8    CSR data width
//  RD_LAT      1    csr_rdata_i valid this many cycles after csr_re_o (1..3)
//  LOCK_MAX    256  max cycles a locked master keeps the grant while others request
// PORTS
//  clk          in   1                  system clock
//  rst          in   1                  reset; asynchronous, active-low
//  req_i        in   NUM_REQ            per-master request; held until matching ack_o bit
//  we_i         in   NUM_REQ            per-master 1=write 0=read
//  lock_i       in   NUM_REQ            per-master keep-grant (SPI: ss low)
//  addr_i       in   NUM_REQ*ADDR_W     packed addresses, master k at [k*ADDR_W +: ADDR_W]
//  wdata_i      in   NUM_REQ*DATA_W     packed write data
//  ack_o        out  NUM_REQ            one-cycle completion pulse to granted master
//  rdata_o      out  DATA_W             read data, valid when ack_o pulses for a read
//  gnt_o        out  NUM_REQ            one-hot current owner, 0 when idle
//  csr_addr_o   out  ADDR_W             to register bank
//  csr_we_o     out  1                  one-cycle write strobe
//  csr_re_o     out  1                  one-cycle read strobe
//  csr_wdata_o  out  DATA_W             write data
//  csr_rdata_i  in   DATA_W             read data from bank
//  lock_brk_o   out  1                  one-cycle pulse when watchdog revokes a lock
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, round-robin pointer = master 0, hold counter 0.
//  FSM: IDLE -> ISSUE -> (write) ACK | (read) WAIT x(RD_LAT-1) -> ACK -> IDLE or ISSUE.
//   IDLE: if gnt_o!=0 and owner req_i=1 -> ISSUE. Else pick first requester at/after pointer,
//    set gnt_o, go ISSUE next cycle. Grant change costs 1 cycle; no requests -> stay IDLE.
//   ISSUE: drive csr_addr_o/csr_wdata_o from owner slice (registered), pulse csr_we_o or csr_re_o.
//   WAIT: count RD_LAT; capture csr_rdata_i into rdata_o on the RD_LAT-th cycle after strobe.
//   ACK: ack_o[owner]=1 one cycle. Write latency req->ack = 2 cycles (grant held), read = 1+RD_LAT+... :
//    fixed at 2+RD_LAT-1 cycles from ISSUE entry measured to ack; masters must drop/replace req the
//    cycle after ack (req seen high in ACK cycle is ignored).
//  Grant release after ACK: if owner lock_i=1 and hold counter < LOCK_MAX, keep gnt_o, go IDLE
//   (back-to-back burst: next req issues without re-arbitration). Else clear gnt_o, pointer =
//   owner+1 mod NUM_REQ.
//  Lock dropped while idle-granted: gnt_o clears next cycle, pointer advances.
//  Hold counter: increments each cycle gnt_o!=0 AND lock_i[owner]=1 AND any other req_i=1; saturates;
//   clears on grant change. At LOCK_MAX the current transaction completes, then grant is forced away,
//   lock_brk_o pulses with that ACK; owner re-enters arbitration normally.
//  Owner drops req_i mid-transaction: access already strobed is not cancelled; ack_o still pulses.
//  Simultaneous requests: round-robin order only; lowest index wins at reset.
//  csr_we_o/csr_re_o never both high; never asserted outside ISSUE.
//  Reset mid-transaction: abort immediately, no ack, strobes low asynchronously.
// STRUCTURE
//  Shared package csr_pkg: ADDR_W/DATA_W constants, FSM state encoding (IDLE/ISSUE/WAIT/ACK),
//  master index constants REQ_SPI=0, REQ_NKMD=1. One sub-module: rr_pick (NUM_REQ-wide
//  round-robin priority encoder: req vector + pointer -> one-hot grant, combinational).
//  Everything else (FSM, latency counter, hold counter, data muxes) in this module.
// TESTING
//  1 SPI write 12'h003<=8'h99 alone -> csr_we_o one cycle, addr 003 data 99, ack_o=01, gnt_o back to 0.
//  2 SPI locked burst reads 12'h900..903 (RD_LAT=1, bank returns addr[7:0]) -> rdata 00,01,02,03,
//    one arbitration cycle only, gnt_o=01 throughout.
//  3 Both request same cycle after reset, no lock -> SPI served first, NKMD next, then pointer=0;
//    repeat -> alternates 01,10,01,10.
//  4 SPI lock held with continuous req, NKMD requesting, LOCK_MAX=8 -> lock_brk_o pulses, NKMD
//    write dbgin 12'h603<=8'hac completes before next SPI access.
//  5 RD_LAT=3: NKMD read -> ack_o 3 cycles after csr_re_o with captured data; no strobe overlap.
//  6 rst low during WAIT -> all outputs 0 at once; after release first request re-arbitrates from master 0.

Source files
------------

// File: rtl/csr_bus_arbiter_pkg.sv
// rtl/csr_bus_arbiter_pkg.sv - shared constants and FSM encoding for the CSR bus arbiter
package csr_bus_arbiter_pkg;

    localparam int CSR_ADDR_W = 12;
    localparam int CSR_DATA_W = 8;

    localparam int REQ_SPI  = 0;
    localparam int REQ_NKMD = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } arb_state_t;

endpackage

// File: rtl/csr_bus_arbiter_rr_pick.sv
// rtl/csr_bus_arbiter_rr_pick.sv - combinational round-robin priority encoder
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;
    int   idx;

    // Scan starting at the pointer and wrapping, so the master just served ranks last.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/csr_bus_arbiter.sv
// rtl/csr_bus_arbiter.sv - round-robin CSR bus arbiter with burst lock and lock-hold watchdog
module csr_bus_arbiter
    import csr_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = CSR_ADDR_W,
    parameter int DATA_W   = CSR_DATA_W,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ-1:0]        lock_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [ADDR_W-1:0]         csr_addr_o,
    output logic                      csr_we_o,
    output logic                      csr_re_o,
    output logic [DATA_W-1:0]         csr_wdata_o,
    input  logic [DATA_W-1:0]         csr_rdata_i,
    output logic                      lock_brk_o
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = $clog2(LOCK_MAX + 1);
    localparam int LAT_W  = 2;

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                we_q, we_d;

    logic [NUM_REQ-1:0]  pick;
    logic [PTR_W-1:0]    owner, owner_nxt, pick_idx, sel_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic                req_own, lock_own, others_req, hold_max;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick)
    );

    always_comb begin
        owner    = '0;
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) owner = PTR_W'(i);
            if (pick[i])  pick_idx = PTR_W'(i);
        end
    end

    assign owner_nxt  = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign req_own    = |(req_i & gnt_q);
    assign lock_own   = |(lock_i & gnt_q);
    assign others_req = |(req_i & ~gnt_q);
    assign hold_max   = (hold_q == HOLD_W'(LOCK_MAX));

    // A held grant issues for its owner; otherwise the freshly picked master is issued.
    always_comb begin
        sel_idx   = (gnt_q != '0) ? owner : pick_idx;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == PTR_W'(i)) begin
                sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata_i[i*DATA_W +: DATA_W];
                sel_we    = we_i[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        lat_d   = lat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_q != '0) begin
                    if (req_own) begin
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        we_d    = sel_we;
                        state_d = ST_ISSUE;
                    end else if (!lock_own) begin
                        gnt_d = '0;
                        ptr_d = owner_nxt;
                    end
                end else if (pick != '0) begin
                    gnt_d   = pick;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q || RD_LAT == 1) begin
                    state_d = ST_ACK;
                end else begin
                    lat_d   = LAT_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == LAT_W'(RD_LAT - 1)) begin
                    state_d = ST_ACK;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ST_ACK: begin
                if (!we_q) begin
                    rdata_d = csr_rdata_i;
                end
                // Locked owners keep the bus for the next burst beat until the watchdog trips.
                if (!(lock_own && !hold_max)) begin
                    gnt_d = '0;
                    ptr_d = owner_nxt;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_d = hold_q;
        if (gnt_d != gnt_q) begin
            hold_d = '0;
        end else if ((gnt_q != '0) && lock_own && others_req && !hold_max) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            lat_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            lat_q   <= lat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign ack_o       = (state_q == ST_ACK) ? gnt_q : '0;
    assign rdata_o     = (state_q == ST_ACK && !we_q) ? csr_rdata_i : rdata_q;
    assign csr_addr_o  = addr_q;
    assign csr_wdata_o = wdata_q;
    assign csr_we_o    = (state_q == ST_ISSUE) && we_q;
    assign csr_re_o    = (state_q == ST_ISSUE) && !we_q;
    assign lock_brk_o  = (state_q == ST_ACK) && lock_own && hold_max;

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// tb/tb_csr_bus_arbiter.sv - directed self-checking bench for csr_bus_arbiter
module tb_csr_bus_arbiter;
    import csr_bus_arbiter_pkg::*;

    typedef struct packed {
        logic        we;
        logic        lock;
        logic [11:0] addr;
        logic [7:0]  wd;
    } op_t;

    typedef struct packed {
        logic [2:0]  kind;
        logic [1:0]  who;
        logic [11:0] addr;
        logic [7:0]  data;
        logic [15:0] cyc;
    } ev_t;

    localparam logic [2:0] EV_WR = 3'd1, EV_RD = 3'd2, EV_ACK = 3'd3, EV_BRK = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0, we = '0, lock = '0;
    logic [23:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  ack, gnt;
    logic [7:0]  rdata, csr_wdata, csr_rdata;
    logic [11:0] csr_addr;
    logic        csr_we, csr_re, lock_brk;
    logic [7:0]  bank_rd = '0;

    logic [1:0]  req3 = '0, we3 = '0, lock3 = '0;
    logic [23:0] addr3 = '0;
    logic [15:0] wdata3 = '0;
    logic [1:0]  ack3, gnt3;
    logic [7:0]  rdata3, csr_wdata3, csr_rdata3;
    logic [11:0] csr_addr3;
    logic        csr_we3, csr_re3, lock_brk3;
    logic [7:0]  p1 = '0, p2 = '0, p3 = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int n_gchg, n_ovl;
    int ovl3 = 0;
    op_t mq[2][$];
    ev_t ev[$];
    ev_t xq[$];

    always #5 clk = ~clk;

    csr_bus_arbiter #(.NUM_REQ(2), .ADDR_W(12), .DATA_W(8), .RD_LAT(1), .LOCK_MAX(8)) dut (
        .clk(clk), .rst(rst_n), .req_i(req), .we_i(we), .lock_i(lock), .addr_i(addr),
        .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .gnt_o(gnt), .csr_addr_o(csr_addr),
        .csr_we_o(csr_we), .csr_re_o(csr_re), .csr_wdata_o(csr_wdata),
        .csr_rdata_i(csr_rdata), .lock_brk_o(lock_brk)
    );

    csr_bus_arbiter #(.NUM_REQ(2), .ADDR_W(12), .DATA_W(8), .RD_LAT(3), .LOCK_MAX(256)) dut3 (
        .clk(clk), .rst(rst_n), .req_i(req3), .we_i(we3), .lock_i(lock3), .addr_i(addr3),
        .wdata_i(wdata3), .ack_o(ack3), .rdata_o(rdata3), .gnt_o(gnt3), .csr_addr_o(csr_addr3),
        .csr_we_o(csr_we3), .csr_re_o(csr_re3), .csr_wdata_o(csr_wdata3),
        .csr_rdata_i(csr_rdata3), .lock_brk_o(lock_brk3)
    );

    // Register bank models: RD_LAT=1 returns addr[7:0]; RD_LAT=3 returns addr[7:0]^5a.
    always @(posedge clk) begin
        if (csr_re) bank_rd <= csr_addr[7:0];
        p1 <= csr_re3 ? (csr_addr3[7:0] ^ 8'h5a) : 8'h00;
        p2 <= p1;
        p3 <= p2;
    end
    assign csr_rdata  = bank_rd;
    assign csr_rdata3 = p3;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic op(input int k, input logic w, input logic l, input logic [11:0] a, input logic [7:0] d);
        mq[k].push_back('{w, l, a, d});
    endtask

    task automatic xe(input logic [2:0] kind, input logic [1:0] who, input logic [11:0] a, input logic [7:0] d, input int c);
        xq.push_back('{kind, who, a, d, 16'(c)});
    endtask

    task automatic load(input int k);
        if (mq[k].size() > 0) begin
            req[k]            = 1'b1;
            we[k]             = mq[k][0].we;
            lock[k]           = mq[k][0].lock;
            addr[k*12 +: 12]  = mq[k][0].addr;
            wdata[k*8 +: 8]   = mq[k][0].wd;
        end else begin
            req[k]  = 1'b0;
            lock[k] = 1'b0;
        end
    endtask

    // Masters replay their op queues; the next op is presented in the ack cycle.
    task automatic run(input int max_cyc);
        logic [1:0] gprev;
        int tail;
        ev.delete();
        n_gchg = 0;
        n_ovl  = 0;
        tail   = 0;
        gprev  = gnt;
        load(REQ_SPI);
        load(REQ_NKMD);
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            tick();
            if (csr_we) ev.push_back('{EV_WR, gnt, csr_addr, csr_wdata, 16'(cyc)});
            if (csr_re) ev.push_back('{EV_RD, gnt, csr_addr, 8'h00, 16'(cyc)});
            if (csr_we && csr_re) n_ovl++;
            if (gnt !== gprev) n_gchg++;
            gprev = gnt;
            for (int k = 0; k < 2; k++) begin
                if (ack[k]) begin
                    if (mq[k].size() > 0) begin
                        ev.push_back('{EV_ACK, ack, 12'h000, mq[k][0].we ? 8'h00 : rdata, 16'(cyc)});
                        void'(mq[k].pop_front());
                    end else begin
                        ev.push_back('{EV_ACK, ack, 12'h000, rdata, 16'(cyc)});
                    end
                    load(k);
                end
            end
            if (lock_brk) ev.push_back('{EV_BRK, gnt, 12'h000, 8'h00, 16'(cyc)});
            if (mq[0].size() == 0 && mq[1].size() == 0) tail++;
            if (tail == 3) break;
        end
        check_val("ops_left", 64'(mq[0].size() + mq[1].size()), 64'd0);
        mq[0].delete();
        mq[1].delete();
        load(0);
        load(1);
    endtask

    task automatic cmp_ev(input string tag);
        check_val({tag, "_nev"}, 64'(ev.size()), 64'(xq.size()));
        for (int i = 0; i < xq.size() && i < ev.size(); i++) begin
            check_val($sformatf("%s_ev%0d", tag, i), 64'(ev[i]), 64'(xq[i]));
        end
        xq.delete();
    endtask

    task automatic txn3(input int k, input logic w, input logic [11:0] a, input logic [7:0] d,
                        output int s_c, output int a_c, output int ns, output logic [7:0] rd,
                        output logic [1:0] av);
        s_c = -1; a_c = -1; ns = 0; rd = '0; av = '0;
        req3[k] = 1'b1;
        we3[k]  = w;
        addr3[k*12 +: 12] = a;
        wdata3[k*8 +: 8]  = d;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (csr_we3 || csr_re3) begin s_c = c; ns++; end
            if (csr_we3 && csr_re3) ovl3++;
            if (ack3 != 2'b00) begin a_c = c; rd = rdata3; av = ack3; break; end
        end
        req3[k] = 1'b0;
        tick();
    endtask

    initial begin
        int s_c, a_c, ns;
        logic [7:0] rd;
        logic [1:0] av;

        #1;
        check_val("rst_outs", {ack, rdata, gnt, csr_addr, csr_we, csr_re, csr_wdata, lock_brk}, 64'd0);
        check_val("rst_outs3", {ack3, rdata3, gnt3, csr_addr3, csr_we3, csr_re3, csr_wdata3, lock_brk3}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: lone SPI write
        op(REQ_SPI, 1'b1, 1'b0, 12'h003, 8'h99);
        run(40);
        xe(EV_WR, 2'b01, 12'h003, 8'h99, 1);
        xe(EV_ACK, 2'b01, 12'h000, 8'h00, 2);
        cmp_ev("t1");
        check_val("t1_gchg", 64'(n_gchg), 64'd2);
        check_val("t1_gnt_end", 64'(gnt), 64'd0);

        // 2: locked SPI read burst, grant held throughout
        for (int i = 0; i < 4; i++) op(REQ_SPI, 1'b0, 1'b1, 12'h900 + 12'(i), 8'h00);
        run(60);
        for (int i = 0; i < 4; i++) begin
            xe(EV_RD, 2'b01, 12'h900 + 12'(i), 8'h00, 1 + 3*i);
            xe(EV_ACK, 2'b01, 12'h000, 8'(i), 2 + 3*i);
        end
        cmp_ev("t2");
        check_val("t2_gchg", 64'(n_gchg), 64'd2);
        check_val("t2_ovl", 64'(n_ovl), 64'd0);

        // 3: simultaneous requests alternate from master 0
        do_reset();
        op(REQ_SPI, 1'b1, 1'b0, 12'h100, 8'h11);
        op(REQ_SPI, 1'b1, 1'b0, 12'h101, 8'h12);
        op(REQ_NKMD, 1'b1, 1'b0, 12'h200, 8'h21);
        op(REQ_NKMD, 1'b1, 1'b0, 12'h201, 8'h22);
        run(60);
        xe(EV_WR, 2'b01, 12'h100, 8'h11, 1);  xe(EV_ACK, 2'b01, 12'h000, 8'h00, 2);
        xe(EV_WR, 2'b10, 12'h200, 8'h21, 4);  xe(EV_ACK, 2'b10, 12'h000, 8'h00, 5);
        xe(EV_WR, 2'b01, 12'h101, 8'h12, 7);  xe(EV_ACK, 2'b01, 12'h000, 8'h00, 8);
        xe(EV_WR, 2'b10, 12'h201, 8'h22, 10); xe(EV_ACK, 2'b10, 12'h000, 8'h00, 11);
        cmp_ev("t3");
        check_val("t3_gchg", 64'(n_gchg), 64'd8);
        op(REQ_SPI, 1'b1, 1'b0, 12'h102, 8'h13);
        op(REQ_NKMD, 1'b1, 1'b0, 12'h202, 8'h23);
        run(40);
        xe(EV_WR, 2'b01, 12'h102, 8'h13, 1); xe(EV_ACK, 2'b01, 12'h000, 8'h00, 2);
        xe(EV_WR, 2'b10, 12'h202, 8'h23, 4); xe(EV_ACK, 2'b10, 12'h000, 8'h00, 5);
        cmp_ev("t3b");

        // 4: lock watchdog at LOCK_MAX=8 lets NKMD in after the 4th SPI beat
        do_reset();
        for (int i = 0; i < 6; i++) op(REQ_SPI, 1'b1, 1'b1, 12'h010 + 12'(i), 8'ha0 + 8'(i));
        op(REQ_NKMD, 1'b1, 1'b0, 12'h603, 8'hac);
        run(80);
        for (int i = 0; i < 4; i++) begin
            xe(EV_WR, 2'b01, 12'h010 + 12'(i), 8'ha0 + 8'(i), 1 + 3*i);
            xe(EV_ACK, 2'b01, 12'h000, 8'h00, 2 + 3*i);
        end
        xe(EV_BRK, 2'b01, 12'h000, 8'h00, 11);
        xe(EV_WR, 2'b10, 12'h603, 8'hac, 13); xe(EV_ACK, 2'b10, 12'h000, 8'h00, 14);
        xe(EV_WR, 2'b01, 12'h014, 8'ha4, 16); xe(EV_ACK, 2'b01, 12'h000, 8'h00, 17);
        xe(EV_WR, 2'b01, 12'h015, 8'ha5, 19); xe(EV_ACK, 2'b01, 12'h000, 8'h00, 20);
        cmp_ev("t4");
        check_val("t4_gchg", 64'(n_gchg), 64'd6);

        // 5: RD_LAT=3 NKMD read, then SPI write moves the pointer to 1
        txn3(REQ_NKMD, 1'b0, 12'h245, 8'h00, s_c, a_c, ns, rd, av);
        check_val("t5_rd_strobe_cyc", 64'(s_c), 64'd1);
        check_val("t5_rd_nstrobe", 64'(ns), 64'd1);
        check_val("t5_rd_ack_cyc", 64'(a_c), 64'd4);
        check_val("t5_rd_ack", 64'(av), 64'h2);
        check_val("t5_rd_data", 64'(rd), 64'h1f);
        txn3(REQ_SPI, 1'b1, 12'h0aa, 8'h55, s_c, a_c, ns, rd, av);
        check_val("t5_wr_ack_cyc", 64'(a_c), 64'd2);
        check_val("t5_wr_ack", 64'(av), 64'h1);
        check_val("t5_ovl", 64'(ovl3), 64'd0);

        // 6: reset during WAIT aborts and clears the pointer
        req3[REQ_NKMD] = 1'b1;
        we3[REQ_NKMD]  = 1'b0;
        addr3[12 +: 12] = 12'h246;
        tick();
        check_val("t6_re", 64'(csr_re3), 64'd1);
        tick();
        check_val("t6_wait_gnt", 64'(gnt3), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_outs3", {ack3, rdata3, gnt3, csr_addr3, csr_we3, csr_re3, csr_wdata3, lock_brk3}, 64'd0);
        req3 = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        check_val("t6_no_ack", 64'(ack3), 64'd0);
        we3    = 2'b11;
        addr3  = {12'h211, 12'h011};
        wdata3 = {8'h22, 8'h11};
        req3   = 2'b11;
        tick();
        check_val("t6_first_gnt", 64'(gnt3), 64'h1);
        check_val("t6_first_addr", 64'(csr_addr3), 64'h011);
        check_val("t6_first_we", 64'(csr_we3), 64'd1);
        req3 = 2'b00;
        rst_n = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
